// File: rtl/branch_target_buffer.sv
// ----------------------------------------------------------------------------
// branch_target_buffer
//   Direct-mapped branch target buffer with a 2-bit saturating counter per
//   entry. Lookup is combinational from PCF; training comes from the execute
//   stage and is written on the rising clock edge.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   PCF               - fetch PC to look up
//   Predict_branchF   - predict taken (fetch selects Target_finalF)
//   Target_finalF     - predicted target, or PCF+4 when not predicted taken
//   hitF              - valid entry with matching tag for PCF
//   Eval_branch       - execute stage holds a resolved branch/jump this cycle
//   Jalr              - resolved instruction is jalr (no training)
//   PCE, PCSrcE,
//   PCTargetE         - resolved PC, actual outcome and actual taken target
//   Predict_branchE   - prediction that was made for this instruction
//   branch_count,
//   mispredict_count  - statistics counters
//
// Optional feature: define BTB_STATS_EN to build the statistics counters;
// otherwise both count outputs are tied to zero and no counter flops exist.
// ----------------------------------------------------------------------------
module branch_target_buffer #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned TAG_W   = 32 - IDX_W - 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        Predict_branchF,
    output logic [31:0] Target_finalF,
    output logic        hitF,
    input  logic        Eval_branch,
    input  logic        Jalr,
    input  logic [31:0] PCE,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        Predict_branchE,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;

    assign idx_f = PCF[IDX_W+1:2];
    assign tag_f = PCF[31:IDX_W+2];

    always_comb begin
        hitF            = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        Predict_branchF = hitF && ctr_q[idx_f][1];
        Target_finalF   = Predict_branchF ? target_q[idx_f] : PCF + 32'd4;
    end

    // ---------------- training ----------------
    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_e;
    logic             hit_e;
    logic             ent_we;
    logic             ent_valid_d;
    logic [TAG_W-1:0] ent_tag_d;
    logic [31:0]      ent_target_d;
    logic [1:0]       ent_ctr_d;

    assign idx_e = PCE[IDX_W+1:2];
    assign tag_e = PCE[31:IDX_W+2];
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    always_comb begin
        ent_we       = 1'b0;
        ent_valid_d  = valid_q[idx_e];
        ent_tag_d    = tag_q[idx_e];
        ent_target_d = target_q[idx_e];
        ent_ctr_d    = ctr_q[idx_e];
        if (Eval_branch && !Jalr) begin
            if (hit_e) begin
                ent_we = 1'b1;
                if (PCSrcE) begin
                    ent_target_d = PCTargetE;
                    if (ctr_q[idx_e] != 2'b11) ent_ctr_d = ctr_q[idx_e] + 2'b01;
                end else begin
                    if (ctr_q[idx_e] != 2'b00) ent_ctr_d = ctr_q[idx_e] - 2'b01;
                end
            end else if (PCSrcE) begin
                // Allocate taken branches only; a conflicting entry is evicted.
                ent_we       = 1'b1;
                ent_valid_d  = 1'b1;
                ent_tag_d    = tag_e;
                ent_target_d = PCTargetE;
                ent_ctr_d    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (ent_we) begin
            valid_q[idx_e]  <= ent_valid_d;
            tag_q[idx_e]    <= ent_tag_d;
            target_q[idx_e] <= ent_target_d;
            ctr_q[idx_e]    <= ent_ctr_d;
        end
    end

    // ---------------- statistics ----------------
`ifdef BTB_STATS_EN
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (Eval_branch) begin
            branch_count_d = branch_count_q + 32'd1;
            // Jalr is counted as a branch but never as a mispredict.
            if (!Jalr && (Predict_branchE != PCSrcE)) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
`else
    logic unused_stats;
    assign unused_stats     = Predict_branchE;
    assign branch_count     = 32'h0;
    assign mispredict_count = 32'h0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    localparam int NENT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        Predict_branchF;
    logic [31:0] Target_finalF;
    logic        hitF;
    logic        Eval_branch;
    logic        Jalr;
    logic [31:0] PCE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        Predict_branchE;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    branch_target_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .PCF              (PCF),
        .Predict_branchF  (Predict_branchF),
        .Target_finalF    (Target_finalF),
        .hitF             (hitF),
        .Eval_branch      (Eval_branch),
        .Jalr             (Jalr),
        .PCE              (PCE),
        .PCSrcE           (PCSrcE),
        .PCTargetE        (PCTargetE),
        .Predict_branchE  (Predict_branchE),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one record per index, full upper PC bits as tag,
    // counter as a plain integer 0..3.
    bit          m_valid [NENT];
    int unsigned m_tag   [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_ctr   [NENT];
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    function automatic bit model_hit(input logic [31:0] pc);
        int i;
        i = int'((pc >> 2) % NENT);
        return m_valid[i] && (m_tag[i] == (pc >> 6));
    endfunction

    // One cycle: drive inputs, check lookup against pre-update model at the
    // falling edge, then advance the model across the rising edge.
    task automatic step(input bit r, input bit ev, input bit jr, input logic [31:0] pce,
                        input bit src, input logic [31:0] tgt, input bit pe,
                        input logic [31:0] pcf);
        int i;
        int u;
        bit hit;
        bit pred;
        rst = r; Eval_branch = ev; Jalr = jr; PCE = pce; PCSrcE = src;
        PCTargetE = tgt; Predict_branchE = pe; PCF = pcf;
        #4;
        i    = int'((pcf >> 2) % NENT);
        hit  = model_hit(pcf);
        pred = hit && (m_ctr[i] >= 2);
        check_val("hitF", {31'b0, hitF}, {31'b0, hit});
        check_val("Predict_branchF", {31'b0, Predict_branchF}, {31'b0, pred});
        check_val("Target_finalF", Target_finalF, pred ? m_tgt[i] : pcf + 32'd4);
`ifdef BTB_STATS_EN
        check_val("branch_count", branch_count, m_bc);
        check_val("mispredict_count", mispredict_count, m_mc);
`else
        check_val("branch_count", branch_count, 32'h0);
        check_val("mispredict_count", mispredict_count, 32'h0);
`endif
        if (r) begin
            model_reset();
        end else begin
            if (ev) m_bc = m_bc + 1;
            if (ev && !jr && (pe != src)) m_mc = m_mc + 1;
            if (ev && !jr) begin
                u = int'((pce >> 2) % NENT);
                if (model_hit(pce)) begin
                    if (src) begin
                        m_ctr[u] = (m_ctr[u] < 3) ? m_ctr[u] + 1 : 3;
                        m_tgt[u] = tgt;
                    end else begin
                        m_ctr[u] = (m_ctr[u] > 0) ? m_ctr[u] - 1 : 0;
                    end
                end else if (src) begin
                    m_valid[u] = 1;
                    m_tag[u]   = pce >> 6;
                    m_tgt[u]   = tgt;
                    m_ctr[u]   = 2;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Small tag/index pool so random traffic hits, aliases and evicts.
    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 7) == 0) return $urandom();
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, NENT - 1)) << 2);
    endfunction

    initial begin
        rst = 1'b1; Eval_branch = 0; Jalr = 0; PCE = 0; PCSrcE = 0;
        PCTargetE = 0; Predict_branchE = 0; PCF = 32'h10;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();

        // Reset state
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h10);
        // Train taken; same-cycle lookup sees old contents
        step(0, 1, 0, 32'h10, 1, 32'h40, 0, 32'h10);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h10);
        // Not-taken x3 then taken: 10 -> 01 -> 00 -> 00 -> 01
        step(0, 1, 0, 32'h10, 0, 32'h0, 1, 32'h10);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h10);
        step(0, 1, 0, 32'h10, 0, 32'h0, 0, 32'h10);
        step(0, 1, 0, 32'h10, 0, 32'h0, 0, 32'h10);
        step(0, 1, 0, 32'h10, 1, 32'h40, 0, 32'h10);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h10);
        // Alias eviction
        step(0, 1, 0, 32'h10, 1, 32'h40, 0, 32'h10);
        step(0, 1, 0, 32'h50, 1, 32'h80, 0, 32'h10);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h10);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h50);
        // Jalr: counted, never allocated
        step(0, 1, 1, 32'h20, 1, 32'h99, 0, 32'h20);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h20);
        // Saturate at strong-taken with target rewrite
        for (int k = 0; k < 4; k++) step(0, 1, 0, 32'h50, 1, 32'h100 + 32'(k), 1, 32'h50);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h50);
        // Reset overrides a same-cycle update
        step(1, 1, 0, 32'h30, 1, 32'h44, 0, 32'h30);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h30);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h50);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), rand_pc(), 1'($urandom_range(0, 1)),
                 $urandom(), 1'($urandom_range(0, 1)), rand_pc());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
